// File: rtl/wta_lif_array.sv
// Winner-take-all array of leaky integrate-and-fire neurons with shift leak,
// refractory hold, subtractive lateral inhibition and a run-time WTA/independent switch.
module wta_lif_array #(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH         = 8,
  parameter int THRESHOLD     = 128,
  parameter int LEAK_SHIFT    = 2,
  parameter int REFRAC_CYCLES = 3,
  parameter int INHIBIT       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         wta_en,
  input  logic [N_NEURONS*WIDTH-1:0]   current,
  input  logic [$clog2(N_NEURONS)-1:0] obs_sel,
  output logic [N_NEURONS-1:0]         spike,
  output logic                         winner_valid,
  output logic [$clog2(N_NEURONS)-1:0] winner_idx,
  output logic [WIDTH-1:0]             obs_state
);

  localparam int SW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC_CYCLES < 2) ? 1 : $clog2(REFRAC_CYCLES + 1);
  localparam logic [WIDTH-1:0] SAT_MAX   = '1;
  localparam logic [WIDTH-1:0] THRESH    = WIDTH'(THRESHOLD);
  // An inhibit at or beyond full scale always floors the victim to zero.
  localparam logic [WIDTH-1:0] INHIB     = (INHIBIT >= 2**WIDTH) ? SAT_MAX : WIDTH'(INHIBIT);
  localparam logic [RW-1:0]    REFRAC_LD = RW'(REFRAC_CYCLES);

  logic [WIDTH-1:0] state_q  [N_NEURONS];
  logic [WIDTH-1:0] state_d  [N_NEURONS];
  logic [RW-1:0]    refrac_q [N_NEURONS];
  logic [RW-1:0]    refrac_d [N_NEURONS];
  logic [WIDTH-1:0] sum      [N_NEURONS];
  logic [N_NEURONS-1:0] refr;
  logic [N_NEURONS-1:0] cand;
  logic [N_NEURONS-1:0] spike_d;
  logic                 any_cand;
  logic [SW-1:0]        win_idx;
  logic [SW-1:0]        idx_d;
  logic [WIDTH-1:0]     best_sum;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   raw;
    assign leak    = state_q[g] >> LEAK_SHIFT;
    assign raw     = {1'b0, state_q[g]} - {1'b0, leak} + {1'b0, current[g*WIDTH +: WIDTH]};
    assign sum[g]  = raw[WIDTH] ? SAT_MAX : raw[WIDTH-1:0];
    assign refr[g] = |refrac_q[g];
    assign cand[g] = !refr[g] && (sum[g] >= THRESH);
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    any_cand = 1'b0;
    win_idx  = '0;
    best_sum = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (cand[i] && (!any_cand || sum[i] > best_sum)) begin
        any_cand = 1'b1;
        win_idx  = SW'(i);
        best_sum = sum[i];
      end
    end
  end

  always_comb begin
    spike_d = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      state_d[i]  = state_q[i];
      refrac_d[i] = refrac_q[i];
      if (en) begin
        if (refr[i]) begin
          refrac_d[i] = refrac_q[i] - RW'(1);
          state_d[i]  = '0;
        end else if (wta_en && any_cand) begin
          if (win_idx == SW'(i)) begin
            state_d[i]  = '0;
            refrac_d[i] = REFRAC_LD;
            spike_d[i]  = 1'b1;
          end else begin
            state_d[i] = (sum[i] > INHIB) ? (sum[i] - INHIB) : '0;
          end
        end else if (!wta_en && cand[i]) begin
          state_d[i]  = '0;
          refrac_d[i] = REFRAC_LD;
          spike_d[i]  = 1'b1;
        end else begin
          state_d[i] = sum[i];
        end
      end
    end
  end

  always_comb begin
    idx_d = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (spike_d[i]) idx_d = SW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= '0;
        refrac_q[i] <= '0;
      end
      spike        <= '0;
      winner_valid <= 1'b0;
      winner_idx   <= '0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= state_d[i];
        refrac_q[i] <= refrac_d[i];
      end
      spike        <= spike_d;
      winner_valid <= |spike_d;
      winner_idx   <= idx_d;
    end
  end

  assign obs_state = state_q[obs_sel];

endmodule
